// File: rtl/ext_pipe.sv
// Pipelined immediate extender (ZERO / SIGN / LUI / BRANCH) for the MIPS decode-to-ALU path.
// A valid/ready front end with an output register plus one skid register absorbs a one-cycle stall.
module ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_neg
);

    localparam int PAD_W = OUT_W - IN_W;

    generate
        if (OUT_W < IN_W + 2) begin : g_width_check
            $error("ext_pipe: OUT_W must be >= IN_W+2");
        end
    endgenerate

    typedef enum logic [1:0] {
        MODE_ZERO   = 2'd0,
        MODE_SIGN   = 2'd1,
        MODE_LUI    = 2'd2,
        MODE_BRANCH = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic [TAG_W-1:0]   out_tag_q, out_tag_d;
    logic [OUT_W-1:0]   skid_data_q, skid_data_d;
    logic [TAG_W-1:0]   skid_tag_q, skid_tag_d;

    logic               accept;
    logic               load_out;
    logic               load_skid;
    logic               out_from_skid;
    logic [OUT_W-1:0]   sign_ext;
    logic [OUT_W-1:0]   ext_result;

    assign accept = in_valid & in_ready_q;

    // Extension of the raw immediate; only captured on accept.
    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sign_ext   = {{PAD_W{in_data[IN_W-1]}}, in_data};
        ext_result = '0;
        case (mode_e'(in_mode))
            MODE_ZERO:   ext_result = {{PAD_W{1'b0}}, in_data};
            MODE_SIGN:   ext_result = sign_ext;
            MODE_LUI:    ext_result = {in_data, {PAD_W{1'b0}}};
            MODE_BRANCH: ext_result = sign_ext << 2;
            default:     ext_result = '0;
        endcase
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) state_d = ST_ONE;
            end
            ST_ONE: begin
                if (accept && !out_ready)      state_d = ST_TWO;
                else if (!accept && out_ready) state_d = ST_EMPTY;
            end
            ST_TWO: begin
                if (out_ready) state_d = ST_ONE;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Output / datapath-control logic.
    always_comb begin
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                load_out = accept;
            end
            ST_ONE: begin
                load_out  = accept & out_ready;
                load_skid = accept & ~out_ready;
            end
            ST_TWO: begin
                load_out      = out_ready;
                out_from_skid = 1'b1;
            end
            default: begin
                load_out = 1'b0;
            end
        endcase
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        skid_data_d = skid_data_q;
        skid_tag_d  = skid_tag_q;
        if (load_out) begin
            out_data_d = out_from_skid ? skid_data_q : ext_result;
            out_tag_d  = out_from_skid ? skid_tag_q  : in_tag;
        end
        if (load_skid) begin
            skid_data_d = ext_result;
            skid_tag_d  = in_tag;
        end
        in_ready_d = (state_d != ST_TWO);
    end

    // NOTE: the data registers are reset too, because out_data/out_tag must read zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q  <= 1'b1;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            skid_data_q <= skid_data_d;
            skid_tag_q  <= skid_tag_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_neg   = out_data_q[OUT_W-1];

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: directed vector table, backpressure and reset sequences,
// and a randomised valid/ready run, all backed by a scoreboard queue.
module tb_ext_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_neg;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;

    ext_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_neg   (out_neg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  tag;
    } exp_t;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  mode;
        logic [31:0] exp;
        logic        neg;
    } vec_t;

    exp_t sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model, written for IN_W=16 / OUT_W=32.
    function automatic logic [31:0] model(input logic [15:0] a, input logic [1:0] m);
        logic [31:0] s;
        s = a[15] ? {16'hFFFF, a} : {16'h0000, a};
        case (m)
            2'd0:    return {16'h0000, a};
            2'd1:    return s;
            2'd2:    return {a, 16'h0000};
            default: return {s[29:0], 2'b00};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: samples on the falling edge, away from the active edge.
    initial begin
        logic        stall_prev;
        logic [31:0] data_prev;
        logic [4:0]  tag_prev;
        exp_t        e;
        stall_prev = 1'b0;
        data_prev  = '0;
        tag_prev   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb_q.delete();
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_valid", 64'(out_valid), 64'd1);
                    check("stall_data", 64'(out_data), 64'(data_prev));
                    check("stall_tag", 64'(out_tag), 64'(tag_prev));
                end
                if (out_valid && out_ready) begin
                    check("sb_pending", 64'(sb_q.size() != 0), 64'd1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("sb_data", 64'(out_data), 64'(e.data));
                        check("sb_tag", 64'(out_tag), 64'(e.tag));
                        check("sb_neg", 64'(out_neg), 64'(e.data[31]));
                    end
                    n_out++;
                end
                if (in_valid && in_ready) begin
                    e.data = model(in_data, in_mode);
                    e.tag  = in_tag;
                    sb_q.push_back(e);
                end
                stall_prev = out_valid && !out_ready;
                data_prev  = out_data;
                tag_prev   = out_tag;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[6];
        int   sent;
        int   cycles;
        int   waited;

        vecs[0] = '{16'h8001, 2'd0, 32'h0000_8001, 1'b0};
        vecs[1] = '{16'h8001, 2'd1, 32'hFFFF_8001, 1'b1};
        vecs[2] = '{16'h8001, 2'd2, 32'h8001_0000, 1'b1};
        vecs[3] = '{16'h8001, 2'd3, 32'hFFFE_0004, 1'b1};
        vecs[4] = '{16'h7FFF, 2'd1, 32'h0000_7FFF, 1'b0};
        vecs[5] = '{16'h7FFF, 2'd3, 32'h0001_FFFC, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_neg", 64'(out_neg), 64'd0);
        repeat (2) tick();
        rst = 1'b0;

        // Directed vectors, one cycle latency each.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[i].data;
            in_mode  = vecs[i].mode;
            in_tag   = 5'(i);
            tick();
            in_valid = 1'b0;
            check("vec_valid", 64'(out_valid), 64'd1);
            check("vec_data", 64'(out_data), 64'(vecs[i].exp));
            check("vec_neg", 64'(out_neg), 64'(vecs[i].neg));
            check("vec_tag", 64'(out_tag), 64'(i));
        end
        tick();
        check("vec_drained", 64'(out_valid), 64'd0);

        // Back-to-back stream of 8.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 16'($urandom);
            in_mode  = 2'($urandom);
            in_tag   = 5'(i);
            tick();
            check("stream_in_ready", 64'(in_ready), 64'd1);
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_tag", 64'(out_tag), 64'(i));
        end
        in_valid = 1'b0;
        tick();
        check("stream_drained", 64'(out_valid), 64'd0);

        // Backpressure: two accepted, third held upstream.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        in_mode   = 2'd1;
        in_tag    = 5'd1;
        tick();
        check("bp_ready_after1", 64'(in_ready), 64'd1);
        check("bp_tag_after1", 64'(out_tag), 64'd1);
        in_data = 16'hF00D;
        in_mode = 2'd3;
        in_tag  = 5'd2;
        tick();
        check("bp_ready_after2", 64'(in_ready), 64'd0);
        check("bp_tag_after2", 64'(out_tag), 64'd1);
        in_tag = 5'd3;
        for (int i = 0; i < 3; i++) begin
            in_data = 16'($urandom);
            in_mode = 2'($urandom);
            tick();
            check("bp_hold_ready", 64'(in_ready), 64'd0);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_tag", 64'(out_tag), 64'd1);
        end
        in_data   = 16'h8000;
        in_mode   = 2'd2;
        out_ready = 1'b1;
        tick();
        check("bp_rel_tag2", 64'(out_tag), 64'd2);
        check("bp_rel_ready", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp_rel_tag3", 64'(out_tag), 64'd3);
        check("bp_rel_data3", 64'(out_data), 64'h8000_0000);
        tick();
        check("bp_drained", 64'(out_valid), 64'd0);

        // Asynchronous reset while in TWO.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h0055;
        in_mode   = 2'd0;
        in_tag    = 5'd4;
        tick();
        in_tag = 5'd5;
        tick();
        check("two_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_out_data", 64'(out_data), 64'd0);
        check("arst_out_tag", 64'(out_tag), 64'd0);
        repeat (2) tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h8001;
        in_mode   = 2'd3;
        in_tag    = 5'd9;
        tick();
        in_valid = 1'b0;
        check("post_rst_data", 64'(out_data), 64'hFFFE_0004);
        check("post_rst_tag", 64'(out_tag), 64'd9);
        tick();
        check("post_rst_drained", 64'(out_valid), 64'd0);

        // Randomised valid/ready over 1000 accepted items.
        sent   = 0;
        cycles = 0;
        while (sent < 1000 && cycles < 20000) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_data   = 16'($urandom);
            in_mode   = 2'($urandom);
            in_tag    = 5'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            tick();
            cycles++;
        end
        check("rand_sent", 64'(sent), 64'd1000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        waited    = 0;
        while (sb_q.size() != 0 && waited < 10) begin
            tick();
            waited++;
        end
        tick();
        check("rand_drain_empty", 64'(sb_q.size()), 64'd0);
        check("rand_drained_valid", 64'(out_valid), 64'd0);
        check("total_out", 64'(n_out), 64'd1018);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
Parametrised, pipelined immediate extender for the MIPS datapath. It is the successor to the combinational zero/sign extender.
- Adds LUI placement and branch-offset (sign-extend, shift left 2) modes.
- Widths are generic.
- Uses a valid/ready handshake with a 2-entry skid buffer, so the decode stage can stall without losing immediates.
- Sits between instruction decode and the ALU/branch-target operand muxes.

Parameters:
IN_W, 16, immediate input width
OUT_W, 32, extended output width; must be >= IN_W+2 (elaboration error otherwise)
TAG_W, 5, sideband tag width (e.g. destination register), carried unchanged

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  upstream presents an immediate
in_ready  output  1  block can accept this cycle
in_data  input  IN_W  raw immediate
in_mode  input  2  0=ZERO, 1=SIGN, 2=LUI, 3=BRANCH
in_tag  input  TAG_W  sideband, passed through
out_valid  output  1  out_data/out_tag/out_neg valid
out_ready  input  1  downstream accepts
out_data  output  OUT_W  extended result
out_tag  output  TAG_W  tag of the result
out_neg  output  1  out_data[OUT_W-1]

Behaviour:
- Reset (async, immediate on rst=1): out_valid=0, in_ready=1, out_data=0, out_tag=0, out_neg=0, skid empty. All in-flight items are discarded.
- Transfer: in on in_valid&in_ready; out on out_valid&out_ready, both sampled at the rising edge.
- Arithmetic, computed combinationally from in_data/in_mode and registered at accept:
  - ZERO: {0..., A}.
  - SIGN: {A[IN_W-1] replicated, A}.
  - LUI: A placed in bits [OUT_W-1:OUT_W-IN_W], lower bits 0.
  - BRANCH: SIGN result shifted left 2, truncated to OUT_W; the two LSBs are 0.
- Latency: exactly 1 cycle from accept to out_valid when the output register is free.
- Storage: output register (OUT) plus one skid register (SKID).
- in_ready is registered and equals !SKID_full.
- States:
  - EMPTY (out_valid=0)
  - ONE (OUT full, SKID empty)
  - TWO (OUT and SKID full)
- Transitions:
  - EMPTY: accept -> ONE.
  - ONE, accept and out_ready: stays ONE, OUT reloaded with the new item.
  - ONE, accept and !out_ready: -> TWO, new item goes to SKID, in_ready=0 the next cycle.
  - ONE, no accept and out_ready: -> EMPTY.
  - TWO (in_ready=0, no accept possible), out_ready: SKID moves to OUT -> ONE, in_ready=1 the next cycle.
  - TWO, !out_ready: hold.
- Output stability: out_data and out_tag are held stable while out_valid=1 and out_ready=0.
- Ordering: results leave strictly in acceptance order. No drop and no duplication.
- in_valid=0: no state change other than drain.
- in_data and in_mode are ignored when not accepted.
- Throughput: 1 item per cycle when out_ready is held high.

Test Plan:
- IN_W=16, OUT_W=32, in_data=0x8001, each mode in turn with out_ready=1 -> ZERO 0x00008001, SIGN 0xFFFF8001, LUI 0x80010000, BRANCH 0xFFFE0004; each appears one cycle after accept, out_neg=0,1,1,1.
- in_data=0x7FFF: SIGN -> 0x00007FFF; BRANCH -> 0x0001FFFC, out_neg=0.
- Back-to-back stream, 8 immediates with tags 0..7, out_ready=1 -> 8 consecutive out_valid cycles, tags in order 0..7, in_ready stays 1.
- Backpressure:
  - Hold out_ready=0 and drive 3 items (tags 1,2,3) -> tags 1 and 2 accepted, in_ready=0 from the cycle after the 2nd accept, tag 3 held upstream.
  - Release out_ready -> outputs 1, 2, 3 in order with no loss.
- Assert rst mid-operation in state TWO -> out_valid=0 and in_ready=1 immediately (asynchronous). After release, the first new item emerges with correct data and no stale item appears.
- Randomised valid/ready with a scoreboard over 1000 items -> sequence matches the reference model exactly; out_data is never changed while stalled.
